dds_wave_gen_n: RTL and testbench
=================================

# dds_wave_gen_n

Parametrised multi-channel DDS waveform generator that supersedes the single-voice phase-accumulator/waveform-shaper pair. It holds CHANNELS independent phase accumulators, each with its own phase increment, waveform form and pulse width, all loaded through a register-write port. Per-channel waveforms and a summed mix are produced on a sample strobe. It sits between the note-to-increment stage and the audio DAC/PWM output.

## Interface
- CHANNELS, 4, number of voices (≥1)
- PHASE_W, 32, accumulator and increment width
- OUT_W, 8, per-channel sample width (unsigned, ≤ PHASE_W−1)
- CH_W, max(1, clog2(CHANNELS)), channel index width (derived)
- CLK  in  1  system clock, rising edge
- RESET_N  in  1  asynchronous, active-low reset
- SAMPLE_EN  in  1  one-cycle sample tick; advances all accumulators
- SYNC  in  1  zero all accumulators (hard sync)
- WR_EN  in  1  register write strobe
- WR_CH  in  CH_W  target channel
- WR_SEL  in  2  00 increment, 01 form, 10 pulse width, 11 reserved
- WR_DATA  in  PHASE_W  write data
- WAVE_BUS  out  CHANNELS*OUT_W  registered per-channel samples, ch0 in LSBs
- MIX  out  OUT_W+CH_W  registered unsigned sum of all channels
- MIX_VALID  out  1  one-cycle strobe, MIX updated

## Operation
- Per channel: acc[PHASE_W], inc[PHASE_W], form[3], pw[OUT_W].
- Writes: WR_SEL 00 → inc ← WR_DATA; 01 → form ← WR_DATA[2:0]; 10 → pw ← WR_DATA[OUT_W−1:0]; 11 and WR_CH ≥ CHANNELS ignored.
- SAMPLE_EN: acc ← acc + inc, modulo 2^PHASE_W, wraps silently.
- SYNC (any cycle): acc ← 0 for all channels; overrides SAMPLE_EN in the same cycle (no add).
- Let top = acc[PHASE_W−1 -: OUT_W], sub = acc[PHASE_W−2 -: OUT_W], mid = 2^(OUT_W−1).
- Waveform per form: 000 saw up = top; 001 saw down = ~top; 010 square = (top < pw) ? all-ones : 0; 011 triangle = MSB ? ~sub : sub; 100–111 silence = mid.
- MIX = sum of the CHANNELS samples; the width OUT_W+CH_W never overflows.
- Reset values: acc 0, inc 0, form 100, pw mid; WAVE_BUS each field = mid; MIX = CHANNELS*mid; MIX_VALID 0.
- Reset asserted mid-operation clears all state immediately; the first sample after release follows reset values.

## Timing
- Edge k (SAMPLE_EN=1): acc updated.
- Edge k+1: WAVE_BUS registered from the updated acc, form and pw.
- Edge k+2: MIX registered; MIX_VALID high for exactly the cycle after edge k+2.
- Back-to-back SAMPLE_EN every cycle is supported; the pipeline is fully pipelined, with one MIX_VALID per tick.
- A write in the same cycle as SAMPLE_EN: the accumulator uses the old inc. A form/pw write lands at edge k and is used by the waveform stage at edge k+1.
- Without SAMPLE_EN, WAVE_BUS and MIX hold, except that form/pw writes are reflected only after the next SAMPLE_EN.
- SYNC at edge k: WAVE_BUS at edge k+1 reflects acc=0 (saw up 0x00, triangle 0x00) only if SAMPLE_EN was also high; MIX_VALID follows SAMPLE_EN only.

## Test plan
All cases use CHANNELS=4, PHASE_W=32, OUT_W=8.
- Reset: hold RESET_N low → every WAVE_BUS byte 0x80, MIX 0x200, MIX_VALID 0. Release with SAMPLE_EN idle → values unchanged.
- Saw up: ch0 inc 0x0100_0000, form 000, SAMPLE_EN every cycle → ch0 reads 0x01, 0x02, …, 0xFF, 0x00 (wrap on sample 256). MIX_VALID lags SAMPLE_EN by 2 cycles.
- Square: ch1 inc 0x0400_0000, form 010, pw 0x40 → 64-sample period, 16 samples at 0xFF and 48 at 0x00. pw 0x00 → constant 0x00.
- Triangle: ch2 inc 0x0080_0000, form 011 → rises 0x01 to 0xFF over samples 1–255, then falls 0xFF to 0x00 over samples 256–511; period 512.
- Collision: write inc 0x0200_0000 in the same cycle as SAMPLE_EN, old inc 0x0100_0000 → that tick adds 0x0100_0000, the next tick adds 0x0200_0000. SYNC together with SAMPLE_EN → saw up reads 0x00.
- Mix: all 4 channels saw up with inc 0x0100_0000 → MIX = 4n after sample n (n ≤ 255). WR_CH/WR_SEL=11 writes are ignored. Asserting RESET_N low mid-run → immediate return to reset values.

Source files
------------

// File: rtl/dds_wave_gen_n.sv
// Multi-channel DDS waveform generator.
// Each voice has its own phase accumulator, increment, waveform form and
// pulse width. A sample tick advances all accumulators; the shaped samples
// are registered one cycle later and their sum one cycle after that.
module dds_wave_gen_n #(
    parameter int CHANNELS = 4,
    parameter int PHASE_W  = 32,
    parameter int OUT_W    = 8,
    parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                        CLK,
    input  logic                        RESET_N,
    input  logic                        SAMPLE_EN,
    input  logic                        SYNC,
    input  logic                        WR_EN,
    input  logic [CH_W-1:0]             WR_CH,
    input  logic [1:0]                  WR_SEL,
    input  logic [PHASE_W-1:0]          WR_DATA,
    output logic [CHANNELS*OUT_W-1:0]   WAVE_BUS,
    output logic [OUT_W+CH_W-1:0]       MIX,
    output logic                        MIX_VALID
);

    localparam int MW = OUT_W + CH_W;
    localparam logic [OUT_W-1:0] MID     = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic [MW-1:0]    MIX_RST = MW'(CHANNELS) << (OUT_W - 1);
    localparam logic [2:0]       FORM_SILENCE = 3'b100;

    logic [PHASE_W-1:0] acc     [CHANNELS];
    logic [PHASE_W-1:0] inc     [CHANNELS];
    logic [2:0]         form    [CHANNELS];
    logic [OUT_W-1:0]   pw      [CHANNELS];
    logic [OUT_W-1:0]   shaped  [CHANNELS];
    logic [OUT_W-1:0]   wave    [CHANNELS];
    logic [MW-1:0]      sum;
    logic               s1;
    logic               s2;

    function automatic logic [OUT_W-1:0] shape(input logic [PHASE_W-1:0] a,
                                               input logic [2:0]         f,
                                               input logic [OUT_W-1:0]   p);
        logic [OUT_W-1:0] top;
        logic [OUT_W-1:0] sub;
        top = a[PHASE_W-1 -: OUT_W];
        sub = a[PHASE_W-2 -: OUT_W];
        case (f)
            3'b000:  shape = top;
            3'b001:  shape = ~top;
            3'b010:  shape = (top < p) ? {OUT_W{1'b1}} : {OUT_W{1'b0}};
            3'b011:  shape = a[PHASE_W-1] ? ~sub : sub;
            default: shape = MID;
        endcase
    endfunction

    // Per-channel configuration registers loaded through the write port.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < CHANNELS; i++) begin
                inc[i]  <= '0;
                form[i] <= FORM_SILENCE;
                pw[i]   <= MID;
            end
        end else if (WR_EN) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (WR_CH == CH_W'(i)) begin
                    case (WR_SEL)
                        2'b00:   inc[i]  <= WR_DATA;
                        2'b01:   form[i] <= WR_DATA[2:0];
                        2'b10:   pw[i]   <= WR_DATA[OUT_W-1:0];
                        default: ;
                    endcase
                end
            end
        end
    end

    // Phase accumulators; hard sync wins over the sample tick.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < CHANNELS; i++) acc[i] <= '0;
            s1 <= 1'b0;
        end else begin
            s1 <= SAMPLE_EN;
            for (int i = 0; i < CHANNELS; i++) begin
                if (SYNC)
                    acc[i] <= '0;
                else if (SAMPLE_EN)
                    acc[i] <= acc[i] + inc[i];
            end
        end
    end

    // Waveform shaping from the current accumulators and the unsigned sum of the registered samples.
    always_comb begin
        sum = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            shaped[i] = shape(acc[i], form[i], pw[i]);
            sum       = sum + MW'(wave[i]);
        end
    end

    // Sample stage: capture shaped values one cycle after the tick.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < CHANNELS; i++) wave[i] <= MID;
            s2 <= 1'b0;
        end else begin
            s2 <= s1;
            if (s1) begin
                for (int i = 0; i < CHANNELS; i++) wave[i] <= shaped[i];
            end
        end
    end

    // Mix stage: register the channel sum and strobe its validity.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            MIX       <= MIX_RST;
            MIX_VALID <= 1'b0;
        end else begin
            MIX_VALID <= s2;
            if (s2) MIX <= sum;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_bus
        assign WAVE_BUS[g*OUT_W +: OUT_W] = wave[g];
    end

endmodule

// File: tb/tb_dds_wave_gen_n.sv
// Directed bench for dds_wave_gen_n with 4 channels, 32-bit phase, 8-bit samples.
module tb_dds_wave_gen_n;

    logic        CLK;
    logic        RESET_N;
    logic        SAMPLE_EN;
    logic        SYNC;
    logic        WR_EN;
    logic [1:0]  WR_CH;
    logic [1:0]  WR_SEL;
    logic [31:0] WR_DATA;
    logic [31:0] WAVE_BUS;
    logic [9:0]  MIX;
    logic        MIX_VALID;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] bus_at   [0:520];
    logic [9:0]  mix_at   [0:520];
    logic        valid_at [0:520];

    dds_wave_gen_n #(.CHANNELS(4), .PHASE_W(32), .OUT_W(8)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .SAMPLE_EN(SAMPLE_EN), .SYNC(SYNC),
        .WR_EN(WR_EN), .WR_CH(WR_CH), .WR_SEL(WR_SEL), .WR_DATA(WR_DATA),
        .WAVE_BUS(WAVE_BUS), .MIX(MIX), .MIX_VALID(MIX_VALID)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] byte_of(input logic [31:0] bus, input int ch);
        return bus[ch*8 +: 8];
    endfunction

    task automatic wr(input logic [1:0] ch, input logic [1:0] sel, input logic [31:0] data);
        WR_EN = 1'b1; WR_CH = ch; WR_SEL = sel; WR_DATA = data;
        @(negedge CLK);
        WR_EN = 1'b0;
    endtask

    // n ticks back-to-back, then two drain cycles; index j is the j-th negedge.
    task automatic run(input int n);
        for (int j = 1; j <= n + 2; j++) begin
            SAMPLE_EN = (j <= n);
            @(negedge CLK);
            bus_at[j]   = WAVE_BUS;
            mix_at[j]   = MIX;
            valid_at[j] = MIX_VALID;
        end
        SAMPLE_EN = 1'b0;
    endtask

    initial begin
        int highs;
        logic [7:0] e;
        RESET_N = 1'b0; SAMPLE_EN = 1'b0; SYNC = 1'b0;
        WR_EN = 1'b0; WR_CH = '0; WR_SEL = '0; WR_DATA = '0;
        repeat (3) @(negedge CLK);

        // Reset state
        check("rst_bus", WAVE_BUS, 32'h8080_8080);
        check("rst_mix", MIX, 32'h200);
        check("rst_valid", MIX_VALID, 0);
        RESET_N = 1'b1;
        repeat (3) @(negedge CLK);
        check("idle_bus", WAVE_BUS, 32'h8080_8080);
        check("idle_mix", MIX, 32'h200);
        check("idle_valid", MIX_VALID, 0);

        // Saw up on ch0
        wr(0, 2'b00, 32'h0100_0000);
        wr(0, 2'b01, 32'h0);
        run(256);
        check("saw_s1", byte_of(bus_at[2], 0), 8'h01);
        check("saw_s2", byte_of(bus_at[3], 0), 8'h02);
        check("saw_s255", byte_of(bus_at[256], 0), 8'hFF);
        check("saw_wrap", byte_of(bus_at[257], 0), 8'h00);
        check("lag_v1", valid_at[1], 0);
        check("lag_v2", valid_at[2], 0);
        check("lag_v3", valid_at[3], 1);
        check("saw_mix1", mix_at[3], 10'h181);
        check("saw_mix_end", mix_at[258], 10'h180);
        @(negedge CLK);
        check("valid_drop", MIX_VALID, 0);
        check("saw_hold", byte_of(WAVE_BUS, 0), 8'h00);

        // Square on ch1, pw 0x40
        wr(1, 2'b00, 32'h0400_0000);
        wr(1, 2'b10, 32'h40);
        wr(1, 2'b01, 32'h2);
        run(64);
        highs = 0;
        for (int n = 1; n <= 64; n++) begin
            e = ((n % 64) < 16) ? 8'hFF : 8'h00;
            check("square", byte_of(bus_at[n+1], 1), e);
            if (byte_of(bus_at[n+1], 1) == 8'hFF) highs++;
        end
        check("square_highs", highs, 16);
        wr(1, 2'b10, 32'h0);
        @(negedge CLK);
        check("pw_wait", byte_of(WAVE_BUS, 1), 8'hFF);
        run(2);
        check("pw0_a", byte_of(bus_at[2], 1), 8'h00);
        check("pw0_b", byte_of(bus_at[3], 1), 8'h00);

        // Triangle on ch2
        wr(2, 2'b00, 32'h0080_0000);
        wr(2, 2'b01, 32'h3);
        run(512);
        check("tri_1", byte_of(bus_at[2], 2), 8'h01);
        check("tri_255", byte_of(bus_at[256], 2), 8'hFF);
        check("tri_256", byte_of(bus_at[257], 2), 8'hFF);
        check("tri_257", byte_of(bus_at[258], 2), 8'hFE);
        check("tri_511", byte_of(bus_at[512], 2), 8'h00);
        check("tri_512", byte_of(bus_at[513], 2), 8'h00);

        // Increment write colliding with a tick on ch3
        wr(3, 2'b00, 32'h0100_0000);
        wr(3, 2'b01, 32'h0);
        SAMPLE_EN = 1'b1;
        WR_EN = 1'b1; WR_CH = 2'd3; WR_SEL = 2'b00; WR_DATA = 32'h0200_0000;
        @(negedge CLK);
        WR_EN = 1'b0;
        @(negedge CLK);
        SAMPLE_EN = 1'b0;
        check("coll_old_inc", byte_of(WAVE_BUS, 3), 8'h01);
        @(negedge CLK);
        check("coll_new_inc", byte_of(WAVE_BUS, 3), 8'h03);

        // Sync together with a tick
        SYNC = 1'b1; SAMPLE_EN = 1'b1;
        @(negedge CLK);
        SYNC = 1'b0; SAMPLE_EN = 1'b0;
        @(negedge CLK);
        check("sync_bus", WAVE_BUS, 32'h0000_0000);
        @(negedge CLK);
        check("sync_mix", MIX, 0);
        check("sync_valid", MIX_VALID, 1);

        // Mix of four saw-up voices; reserved-select write must be ignored
        wr(1, 2'b00, 32'h0100_0000);
        wr(1, 2'b01, 32'h0);
        wr(2, 2'b00, 32'h0100_0000);
        wr(2, 2'b01, 32'h0);
        wr(3, 2'b00, 32'h0100_0000);
        wr(0, 2'b11, 32'hFFFF_FFFF);
        run(10);
        check("mix_n1", mix_at[3], 10'd4);
        check("mix_n5", mix_at[7], 10'd20);
        check("mix_n10", mix_at[12], 10'd40);
        check("mix_bus10", bus_at[11], 32'h0A0A_0A0A);

        // Reset mid-run
        SAMPLE_EN = 1'b1;
        repeat (3) @(negedge CLK);
        #2 RESET_N = 1'b0;
        #1;
        check("midrst_bus", WAVE_BUS, 32'h8080_8080);
        check("midrst_mix", MIX, 32'h200);
        check("midrst_valid", MIX_VALID, 0);
        SAMPLE_EN = 1'b0;
        @(negedge CLK);
        RESET_N = 1'b1;
        run(1);
        check("post_rst_bus", bus_at[2], 32'h8080_8080);
        check("post_rst_mix", mix_at[3], 10'h200);
        check("post_rst_valid", valid_at[3], 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
